// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit and receive paths.
//   state_t        : transmitter FSM state encoding
//   PAR_*          : encoding of the PARITY parameter
//   calc_baud_div  : clocks per bit period, shared so both ends of a link
//                    derive bit timing identically (truncating division)
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    function automatic int calc_baud_div(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer for the UART transmitter.
//   clk     : rising-edge clock
//   rst     : synchronous reset, active-low
//   restart : hold the counter at zero (asserted while the line is idle)
//   bit_end : high on the last clock of every DIV-clock bit period
module uart_baud_gen #(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic bit_end
);

    localparam int               CNT_W = $clog2(DIV) + 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] baud_cnt;

    assign bit_end = (baud_cnt == LAST);

    // Wrapping at bit_end doubles as the reset-on-state-entry, since every
    // state change out of a busy state happens on a bit_end clock.
    always_ff @(posedge clk) begin
        if (!rst) begin
            baud_cnt <= '0;
        end else if (restart || bit_end) begin
            baud_cnt <= '0;
        end else begin
            baud_cnt <= baud_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_axis_tx.sv
// AXI4-Stream to UART transmitter (LSB first, optional parity, 1/2 stop bits).
//   clk           : rising-edge clock
//   rst           : synchronous reset, active-low
//   s_axis_tdata  : word to send, sampled only at the handshake
//   s_axis_tvalid : beat valid
//   s_axis_tready : high in IDLE and on the final clock of the final stop bit
//   tx            : serial line, registered, idles high
//   tx_busy       : high while a frame is on the line
module uart_axis_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD      = 9600,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] s_axis_tdata,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    output logic                 tx,
    output logic                 tx_busy
);

    localparam int               BAUD_DIV  = calc_baud_div(CLK_FREQ, BAUD);
    localparam int               BIT_W     = $clog2(DATA_BITS);
    localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_BITS - 1);
    localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

    state_t               state, state_next;
    logic [DATA_BITS-1:0] shift_reg, shift_next;
    logic [BIT_W-1:0]     bit_cnt, bit_cnt_next;
    logic                 stop_cnt, stop_cnt_next;
    logic                 par_bit, par_next;
    logic                 tx_next;
    logic                 bit_end;
    logic                 last_stop;
    logic                 handshake;

    function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
        if (PARITY == PAR_EVEN) begin
            return ^d;
        end
        return ~^d;
    endfunction

    uart_baud_gen #(
        .DIV(BAUD_DIV)
    ) u_baud_gen (
        .clk    (clk),
        .rst    (rst),
        .restart(state == ST_IDLE),
        .bit_end(bit_end)
    );

    assign last_stop     = (state == ST_STOP) && bit_end && (stop_cnt == STOP_LAST);
    assign s_axis_tready = rst && ((state == ST_IDLE) || last_stop);
    assign handshake     = s_axis_tvalid && s_axis_tready;
    assign tx_busy       = (state != ST_IDLE);

    always_comb begin
        state_next    = state;
        shift_next    = shift_reg;
        bit_cnt_next  = bit_cnt;
        stop_cnt_next = stop_cnt;
        par_next      = par_bit;
        tx_next       = 1'b1;

        case (state)
            ST_IDLE: begin
                if (handshake) begin
                    state_next = ST_START;
                    shift_next = s_axis_tdata;
                    par_next   = parity_of(s_axis_tdata);
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_next   = ST_DATA;
                    bit_cnt_next = '0;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    shift_next   = shift_reg >> 1;
                    bit_cnt_next = bit_cnt + 1'b1;
                    if (bit_cnt == LAST_BIT) begin
                        stop_cnt_next = 1'b0;
                        if (PARITY != PAR_NONE) begin
                            state_next = ST_PARITY;
                        end else begin
                            state_next = ST_STOP;
                        end
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    state_next    = ST_STOP;
                    stop_cnt_next = 1'b0;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    if (stop_cnt == STOP_LAST) begin
                        // A beat accepted here starts the next frame with no idle gap.
                        if (handshake) begin
                            state_next = ST_START;
                            shift_next = s_axis_tdata;
                            par_next   = parity_of(s_axis_tdata);
                        end else begin
                            state_next = ST_IDLE;
                        end
                    end else begin
                        stop_cnt_next = stop_cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // tx is registered from the next-state view so the line level changes
        // on the same edge as the state, keeping tx and tx_busy aligned.
        case (state_next)
            ST_START:  tx_next = 1'b0;
            ST_DATA:   tx_next = shift_next[0];
            ST_PARITY: tx_next = par_next;
            default:   tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_IDLE;
            shift_reg <= '0;
            bit_cnt   <= '0;
            stop_cnt  <= 1'b0;
            par_bit   <= 1'b0;
            tx        <= 1'b1;
        end else begin
            state     <= state_next;
            shift_reg <= shift_next;
            bit_cnt   <= bit_cnt_next;
            stop_cnt  <= stop_cnt_next;
            par_bit   <= par_next;
            tx        <= tx_next;
        end
    end

endmodule

// File: tb/tb_uart_axis_tx.sv
// Testbench for uart_axis_tx. Four instances cover 8N1, 8E2, 8O2 and 5N1
// with BAUD_DIV = 10. Stimulus pushes each accepted word into a scoreboard
// queue; a per-instance line monitor captures whole frames, decodes them and
// compares against levels derived from the frame-format rules.
module tb_uart_axis_tx;

    localparam int DIV = 10;

    typedef struct {
        int         k;
        logic [7:0] d;
    } exp_t;

    function automatic int db_of(input int k);
        return (k == 3) ? 5 : 8;
    endfunction

    function automatic int par_of(input int k);
        return (k == 1) ? 2 : ((k == 2) ? 1 : 0);
    endfunction

    function automatic int sb_of(input int k);
        return (k == 1 || k == 2) ? 2 : 1;
    endfunction

    logic       clk = 1'b0;
    logic       rstn   [4];
    logic [7:0] tdata  [4];
    logic       tvalid [4];
    logic [3:0] tready;
    logic [3:0] txs;
    logic [3:0] busy;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   prev_start [4];
    int   last_start [4];
    exp_t exp_q [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic pop_exp(input int k, output logic [7:0] d, output logic found);
        found = 1'b0;
        d     = '0;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (exp_q[i].k == k) begin
                d     = exp_q[i].d;
                found = 1'b1;
                exp_q.delete(i);
                break;
            end
        end
    endtask

    // Line levels of one frame, one bit per bit period; unused positions high.
    function automatic logic [15:0] model_levels(input logic [7:0] d, input int db,
                                                 input int par);
        logic [15:0] lv;
        int          ones;
        lv    = '1;
        ones  = 0;
        lv[0] = 1'b0;
        for (int i = 0; i < db; i++) begin
            lv[1 + i] = d[i];
            ones += int'(d[i]);
        end
        if (par == 2) lv[db + 1] = (ones % 2 == 1);
        if (par == 1) lv[db + 1] = (ones % 2 == 0);
        return lv;
    endfunction

    // Called on a falling edge; returns on the falling edge just after the
    // handshake edge, i.e. the first clock of the start bit.
    task automatic send(input int k, input logic [7:0] b, input bit hold);
        int   n;
        exp_t e;
        n         = 0;
        tdata[k]  = b;
        tvalid[k] = 1'b1;
        while (!tready[k] && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!tready[k]) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: inst %0d tready stayed 0, required 1", k);
            tvalid[k] = 1'b0;
            return;
        end
        e.k = k;
        e.d = b & 8'((1 << db_of(k)) - 1);
        exp_q.push_back(e);
        @(negedge clk);
        if (!hold) tvalid[k] = 1'b0;
    endtask

    task automatic wait_idle(input int k);
        int n;
        n = 0;
        @(negedge clk);
        while ((busy[k] || tvalid[k]) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("idle_reached", 32'(busy[k]), 32'd0);
        @(negedge clk);
    endtask

    for (genvar k = 0; k < 4; k++) begin : g_dut
        localparam int DB  = db_of(k);
        localparam int PAR = par_of(k);
        localparam int SB  = sb_of(k);
        localparam int NB  = 1 + DB + ((PAR != 0) ? 1 : 0) + SB;
        localparam int FL  = NB * DIV;

        uart_axis_tx #(
            .CLK_FREQ (1_000_000),
            .BAUD     (100_000),
            .DATA_BITS(DB),
            .PARITY   (PAR),
            .STOP_BITS(SB)
        ) u_dut (
            .clk          (clk),
            .rst          (rstn[k]),
            .s_axis_tdata (tdata[k][DB-1:0]),
            .s_axis_tvalid(tvalid[k]),
            .s_axis_tready(tready[k]),
            .tx           (txs[k]),
            .tx_busy      (busy[k])
        );

        initial begin : mon
            int          n;
            int          p;
            logic        aborted;
            logic        stable;
            logic        bsy_ok;
            logic        rdy_ok;
            logic        found;
            logic [15:0] act_lv;
            logic [7:0]  exp_b;
            logic [7:0]  act_b;
            forever begin
                @(negedge clk);
                if (rstn[k] && !txs[k]) begin
                    prev_start[k] = last_start[k];
                    last_start[k] = cyc;
                    pop_exp(k, exp_b, found);
                    aborted = 1'b0;
                    stable  = 1'b1;
                    bsy_ok  = 1'b1;
                    rdy_ok  = 1'b1;
                    act_lv  = '1;
                    for (n = 0; n < FL; n++) begin
                        if (n > 0) @(negedge clk);
                        if (!rstn[k]) begin
                            aborted = 1'b1;
                            break;
                        end
                        p = n / DIV;
                        if (n % DIV == 0) act_lv[p] = txs[k];
                        else if (txs[k] !== act_lv[p]) stable = 1'b0;
                        if (busy[k] !== 1'b1) bsy_ok = 1'b0;
                        if (tready[k] !== (n == FL - 1)) rdy_ok = 1'b0;
                    end
                    if (!aborted) begin
                        act_b = '0;
                        for (int i = 0; i < DB; i++) act_b[i] = act_lv[i + 1];
                        check("frame_expected", 32'(found), 32'd1);
                        check("line_levels", 32'(act_lv), 32'(model_levels(exp_b, DB, PAR)));
                        check("decoded_word", 32'(act_b), 32'(exp_b));
                        check("bit_period_stable", 32'(stable), 32'd1);
                        check("busy_during_frame", 32'(bsy_ok), 32'd1);
                        check("tready_only_last_clock", 32'(rdy_ok), 32'd1);
                    end
                end
            end
        end
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 4; k++) begin
            rstn[k]       = 1'b0;
            tvalid[k]     = 1'b0;
            tdata[k]      = '0;
            prev_start[k] = 0;
            last_start[k] = 0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            check("rst_tx", 32'(txs[k]), 32'd1);
            check("rst_busy", 32'(busy[k]), 32'd0);
            check("rst_tready", 32'(tready[k]), 32'd0);
            rstn[k] = 1'b1;
        end
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            check("idle_tready", 32'(tready[k]), 32'd1);
            check("idle_tx", 32'(txs[k]), 32'd1);
        end

        // Single 8N1 frame: busy must drop exactly 100 clocks after it rose.
        send(0, 8'h55, 1'b0);
        repeat (100) @(negedge clk);
        check("busy_after_frame", 32'(busy[0]), 32'd0);
        check("tx_after_frame", 32'(txs[0]), 32'd1);
        wait_idle(0);

        // Back-to-back with tvalid held high.
        send(0, 8'hA3, 1'b1);
        send(0, 8'h0F, 1'b0);
        wait_idle(0);
        check("b2b_start_spacing", 32'(last_start[0] - prev_start[0]), 32'd100);

        // Even and odd parity with two stop bits.
        send(1, 8'h07, 1'b0);
        wait_idle(1);
        send(2, 8'h07, 1'b0);
        wait_idle(2);

        // Reset in the middle of a frame, then a clean frame.
        send(0, 8'hFF, 1'b0);
        repeat (35) @(negedge clk);
        rstn[0] = 1'b0;
        @(negedge clk);
        check("midframe_rst_tx", 32'(txs[0]), 32'd1);
        check("midframe_rst_busy", 32'(busy[0]), 32'd0);
        check("midframe_rst_tready", 32'(tready[0]), 32'd0);
        rstn[0] = 1'b1;
        @(negedge clk);
        send(0, 8'h81, 1'b0);
        wait_idle(0);

        // tvalid toggled with changing data while busy must not be taken.
        send(0, 8'h3C, 1'b0);
        for (int i = 0; i < 40; i++) begin
            tvalid[0] = 1'($urandom_range(0, 1));
            tdata[0]  = 8'($urandom);
            @(negedge clk);
        end
        tvalid[0] = 1'b0;
        send(0, 8'hC5, 1'b0);
        wait_idle(0);

        // Five data bits.
        send(3, 8'h1B, 1'b0);
        wait_idle(3);

        // Randomized traffic on every configuration.
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 6; j++) begin
                send(k, 8'($urandom), 1'($urandom_range(0, 1)));
                if (!tvalid[k]) repeat ($urandom_range(0, 12)) @(negedge clk);
            end
            tvalid[k] = 1'b0;
            wait_idle(k);
        end

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
